// File: rtl/result_uart_tx.sv
// result_uart_tx: tags SNN/CNN tile results with route and tile index, buffers them in a FIFO,
// and sends each one as a framed 8N1 UART packet. RESULT_TX_CHECKSUM_EN adds an XOR checksum byte.
module result_uart_tx #(
    parameter int unsigned DVSR       = 100,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned NUM_TILES  = 1200,
    parameter int unsigned IDX_W      = 11
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iCNN_Valid,
    input  logic [7:0]       iCNN_Result,
    input  logic             iSNN_Valid,
    input  logic [7:0]       iSNN_Result,
    output logic             oTx,
    output logic             oBusy,
    output logic             oOverflow,
    output logic             oCollision,
    output logic [IDX_W-1:0] oTileCount,
    output logic             oFrameDone
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned WORD_W = 1 + 8 + IDX_W;
    localparam int unsigned DV_W   = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int unsigned S_MAX  = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int unsigned S_W    = $clog2(S_MAX);
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int unsigned NUM_BYTES = 5;
`else
    localparam int unsigned NUM_BYTES = 4;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    tx_state_e         state_q, state_d;
    logic [DV_W-1:0]   baud_q, baud_d;
    logic [S_W-1:0]    s_cnt_q, s_cnt_d;
    logic [2:0]        n_cnt_q, n_cnt_d;
    logic [2:0]        b_cnt_q, b_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic [WORD_W-1:0] ent_q, ent_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              col_q, col_d;
    logic              fd_q, fd_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];

    logic              empty, full, push_req, push, pop, tick;
    logic [WORD_W-1:0] push_word;
    logic              ent_route;
    logic [7:0]        ent_res;
    logic [IDX_W-1:0]  ent_idx;
    logic [7:0]        byte1, byte2, byte3, next_byte;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_req = iCNN_Valid | iSNN_Valid;
    assign pop      = (state_q == IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
    assign push     = push_req && (!full || pop);
    assign push_word = iCNN_Valid ? {1'b1, iCNN_Result, cnt_q} : {1'b0, iSNN_Result, cnt_q};
    assign tick     = (state_q != IDLE) && (baud_q == DV_W'(DVSR - 1));

    assign ent_route = ent_q[WORD_W-1];
    assign ent_res   = ent_q[IDX_W +: 8];
    assign ent_idx   = ent_q[IDX_W-1:0];
    assign byte1     = {ent_route, 7'(ent_idx >> 8)};
    assign byte2     = ent_idx[7:0];
    assign byte3     = ent_res;

    always_comb begin
        next_byte = byte3;
        case (b_cnt_q)
            3'd0: next_byte = byte1;
            3'd1: next_byte = byte2;
`ifdef RESULT_TX_CHECKSUM_EN
            3'd3: next_byte = byte1 ^ byte2 ^ byte3;
`endif
            default: next_byte = byte3;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        // Dropped results still consume an index so later tiles keep their frame position.
        if (push_req) cnt_d = (cnt_q == IDX_W'(NUM_TILES - 1)) ? '0 : cnt_q + IDX_W'(1);
        ovf_d = ovf_q | (push_req & ~push);
        col_d = col_q | (iCNN_Valid & iSNN_Valid);
    end

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        b_cnt_d = b_cnt_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        ent_d   = ent_q;
        fd_d    = 1'b0;
        baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + DV_W'(1);
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    ent_d   = mem_q[rd_ptr_q[PTR_W-1:0]];
                    shreg_d = 8'hA5;
                    tx_d    = 1'b0;
                    s_cnt_d = '0;
                    n_cnt_d = '0;
                    b_cnt_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt_q == S_W'(15)) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        tx_d    = shreg_q[0];
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt_q == S_W'(15)) begin
                        s_cnt_d = '0;
                        if (n_cnt_q == 3'd7) begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 3'd1;
                            shreg_d = shreg_q >> 1;
                            tx_d    = shreg_q[1];
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_cnt_q == S_W'(SB_TICK - 1)) begin
                        s_cnt_d = '0;
                        if (b_cnt_q == 3'(NUM_BYTES - 1)) begin
                            fd_d    = (ent_idx == IDX_W'(NUM_TILES - 1));
                            state_d = IDLE;
                        end else begin
                            b_cnt_d = b_cnt_q + 3'd1;
                            shreg_d = next_byte;
                            tx_d    = 1'b0;
                            state_d = START;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            s_cnt_q  <= '0;
            n_cnt_q  <= '0;
            b_cnt_q  <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            ent_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            col_q    <= 1'b0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            s_cnt_q  <= s_cnt_d;
            n_cnt_q  <= n_cnt_d;
            b_cnt_q  <= b_cnt_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            ent_q    <= ent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            col_q    <= col_d;
            fd_q     <= fd_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_word;
    end

    assign oTx        = tx_q;
    assign oBusy      = !empty || (state_q != IDLE);
    assign oOverflow  = ovf_q;
    assign oCollision = col_q;
    assign oTileCount = cnt_q;
    assign oFrameDone = fd_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: decodes the serial lines of two instances
// (full-frame and 4-tile-frame) and compares packets, timing and flags with hand-computed values.
`timescale 1ns/1ps
module tb_result_uart_tx;
    localparam int unsigned DVSR     = 2;
    localparam int unsigned BIT_CLKS = 16 * DVSR;
`ifdef RESULT_TX_CHECKSUM_EN
    localparam int unsigned NB = 5;
`else
    localparam int unsigned NB = 4;
`endif
    localparam int unsigned PKT_CLKS = NB * 10 * BIT_CLKS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        c_v = 1'b0, s_v = 1'b0, c4_v = 1'b0, s4_v = 1'b0;
    logic [7:0]  c_d = '0, s_d = '0, c4_d = '0, s4_d = '0;
    logic        tx, busy, ovf, col, fd;
    logic        tx4, busy4, ovf4, col4, fd4;
    logic [10:0] cnt, cnt4;

    result_uart_tx #(.DVSR(DVSR), .SB_TICK(16), .FIFO_DEPTH(16), .NUM_TILES(1200), .IDX_W(11)) u_dut (
        .iClk(clk), .iRst(rst_n),
        .iCNN_Valid(c_v), .iCNN_Result(c_d), .iSNN_Valid(s_v), .iSNN_Result(s_d),
        .oTx(tx), .oBusy(busy), .oOverflow(ovf), .oCollision(col),
        .oTileCount(cnt), .oFrameDone(fd)
    );

    result_uart_tx #(.DVSR(DVSR), .SB_TICK(16), .FIFO_DEPTH(16), .NUM_TILES(4), .IDX_W(11)) u_dut4 (
        .iClk(clk), .iRst(rst_n),
        .iCNN_Valid(c4_v), .iCNN_Result(c4_d), .iSNN_Valid(s4_v), .iSNN_Result(s4_d),
        .oTx(tx4), .oBusy(busy4), .oOverflow(ovf4), .oCollision(col4),
        .oTileCount(cnt4), .oFrameDone(fd4)
    );

    int unsigned n_pass = 0, n_total = 0;
    int unsigned cyc = 0;
    int unsigned ferr = 0;
    int unsigned fd0_cnt = 0, fd4_cnt = 0, fd4_cyc = 0;
    logic [7:0]  rxq0[$], rxq4[$];
    int unsigned st0[$], st4[$];

    typedef struct {
        logic        cv;
        logic [7:0]  cd;
        logic        sv;
        logic [7:0]  sd;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic        col;
        logic [10:0] cnt;
    } vec_t;
    vec_t vt[4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fd) fd0_cnt <= fd0_cnt + 1;
        if (fd4) begin
            fd4_cnt <= fd4_cnt + 1;
            fd4_cyc <= cyc;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    function automatic logic line_of(input bit which);
        return which ? tx4 : tx;
    endfunction

    function automatic logic busy_of(input bit which);
        return which ? busy4 : busy;
    endfunction

    // 8N1 receiver sampling mid-bit on falling clock edges; records each byte and its start cycle.
    task automatic decode(input bit which);
        logic [7:0]  b;
        int unsigned t;
        forever begin
            @(negedge clk);
            if (line_of(which) == 1'b0) begin
                t = cyc;
                repeat (BIT_CLKS / 2) @(negedge clk);
                if (line_of(which) == 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT_CLKS) @(negedge clk);
                        b[i] = line_of(which);
                    end
                    repeat (BIT_CLKS) @(negedge clk);
                    if (line_of(which) != 1'b1) ferr++;
                    if (which) begin
                        rxq4.push_back(b);
                        st4.push_back(t);
                    end else begin
                        rxq0.push_back(b);
                        st0.push_back(t);
                    end
                end
            end
        end
    endtask

    initial decode(1'b0);
    initial decode(1'b1);

    function automatic logic [7:0] get_byte(input bit which);
        if (which) return (rxq4.size() > 0) ? rxq4.pop_front() : 8'hxx;
        return (rxq0.size() > 0) ? rxq0.pop_front() : 8'hxx;
    endfunction

    task automatic check_pkt(input bit which, input string nm,
                             input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] e[5];
        e = '{8'hA5, b1, b2, b3, b1 ^ b2 ^ b3};
        for (int i = 0; i < NB; i++)
            check($sformatf("%s_B%0d", nm, i), {24'h0, get_byte(which)}, {24'h0, e[i]});
    endtask

    task automatic wait_idle(input bit which, input int unsigned bound, input string nm);
        int unsigned n = 0;
        while (busy_of(which) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_idle"}, busy_of(which), 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        int unsigned exp_t;

        vt[0] = '{1'b0, 8'h00, 1'b1, 8'hC3, 8'h00, 8'h01, 8'hC3, 1'b0, 11'd2};
        vt[1] = '{1'b1, 8'h55, 1'b1, 8'h66, 8'h80, 8'h02, 8'h55, 1'b1, 11'd3};
        vt[2] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h80, 8'h03, 8'hFF, 1'b1, 11'd4};
        vt[3] = '{1'b0, 8'h00, 1'b1, 8'h5A, 8'h00, 8'h04, 8'h5A, 1'b1, 11'd5};

        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_col", col, 1'b0);
        check("rst_cnt", cnt, 11'd0);
        check("rst_fd", fd, 1'b0);
        check("rst4_tx", tx4, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single CNN result: exact start-bit length and packet duration.
        @(negedge clk);
        c_v = 1'b1; c_d = 8'h3C;
        @(posedge clk); #1;
        c_v = 1'b0;
        check("t1_tx_at_push", tx, 1'b1);
        check("t1_busy_at_push", busy, 1'b1);
        @(posedge clk); #1;
        check("t1_tx_fall", tx, 1'b0);
        n = 0;
        while (tx == 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t1_start_width", n, BIT_CLKS);
        while (busy && n < 2 * PKT_CLKS) begin
            @(posedge clk); #1;
            n++;
        end
        check("t1_busy_len", n, PKT_CLKS);
        repeat (2) @(negedge clk);
        check_pkt(1'b0, "t1", 8'h80, 8'h00, 8'h3C);
        check("t1_cnt", cnt, 11'd1);

        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            c_v = vt[v].cv; c_d = vt[v].cd; s_v = vt[v].sv; s_d = vt[v].sd;
            @(negedge clk);
            c_v = 1'b0; s_v = 1'b0;
            wait_idle(1'b0, 2 * PKT_CLKS, $sformatf("vec%0d", v));
            check_pkt(1'b0, $sformatf("vec%0d", v), vt[v].b1, vt[v].b2, vt[v].b3);
            check($sformatf("vec%0d_extra", v), rxq0.size(), 0);
            check($sformatf("vec%0d_col", v), col, vt[v].col);
            check($sformatf("vec%0d_cnt", v), cnt, vt[v].cnt);
        end

        // Back-to-back SNN results: no gap inside a packet, one idle clock between packets.
        do_reset();
        rxq0.delete(); st0.delete();
        @(negedge clk);
        s_v = 1'b1; s_d = 8'h11;
        @(negedge clk);
        s_d = 8'h22;
        @(negedge clk);
        s_v = 1'b0;
        wait_idle(1'b0, 3 * PKT_CLKS, "b2b");
        check("b2b_cnt", cnt, 11'd2);
        check("b2b_nbytes", st0.size(), 2 * NB);
        if (st0.size() == 2 * NB) begin
            check("b2b_byte_gap", st0[1] - st0[0], 10 * BIT_CLKS);
            check("b2b_pkt_gap", st0[NB] - st0[NB-1], 10 * BIT_CLKS + 1);
        end
        check_pkt(1'b0, "b2b_p0", 8'h00, 8'h00, 8'h11);
        check_pkt(1'b0, "b2b_p1", 8'h00, 8'h01, 8'h22);

        // 20 back-to-back results into a 16-deep FIFO; one pop happens after the first push.
        do_reset();
        rxq0.delete(); st0.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 17) check("ovf_not_yet", ovf, 1'b0);
            c_v = 1'b1; c_d = 8'(8'h40 + i);
        end
        @(negedge clk);
        c_v = 1'b0;
        check("ovf_flag", ovf, 1'b1);
        check("ovf_cnt", cnt, 11'd20);
        wait_idle(1'b0, 18 * PKT_CLKS, "ovf");
        for (int k = 0; k < 17; k++)
            check_pkt(1'b0, $sformatf("ovf_p%0d", k), 8'h80, 8'(k), 8'(8'h40 + k));
        check("ovf_extra", rxq0.size(), 0);
        check("ovf_still", ovf, 1'b1);

        // 4-tile frame: frame-done pulse once, right after the idx-3 packet; fifth packet wraps to idx 0.
        rxq4.delete(); st4.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s4_v = 1'b1; s4_d = 8'(8'h10 + i);
        end
        @(negedge clk);
        s4_v = 1'b0;
        check("fd_cnt4", cnt4, 11'd1);
        wait_idle(1'b1, 6 * PKT_CLKS, "fd");
        check("fd_pulses", fd4_cnt, 1);
        exp_t = (st4.size() > 3 * NB) ? st4[3*NB] + PKT_CLKS : 0;
        check("fd_timing", fd4_cyc, exp_t);
        for (int k = 0; k < 5; k++)
            check_pkt(1'b1, $sformatf("fd_p%0d", k), 8'h00, 8'(k % 4), 8'(8'h10 + k));
        check("ferr_mid", ferr, 0);

        // Asynchronous reset in the middle of B2's data bits.
        @(negedge clk);
        c_v = 1'b1; s_v = 1'b1; c_d = 8'h99; s_d = 8'h66;
        @(negedge clk);
        c_v = 1'b0; s_v = 1'b0;
        repeat (700) @(negedge clk);
        check("ar_pre_busy", busy, 1'b1);
        check("ar_pre_tx", tx, 1'b0);
        check("ar_pre_col", col, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_tx", tx, 1'b1);
        check("ar_busy", busy, 1'b0);
        check("ar_ovf", ovf, 1'b0);
        check("ar_col", col, 1'b0);
        check("ar_cnt", cnt, 11'd0);
        check("ar_fd", fd, 1'b0);
        repeat (3) @(negedge clk);
        check("ar_tx_held", tx, 1'b1);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        rxq0.delete(); st0.delete(); ferr = 0;
        @(negedge clk);
        c_v = 1'b1; c_d = 8'h77;
        @(negedge clk);
        c_v = 1'b0;
        wait_idle(1'b0, 2 * PKT_CLKS, "ar_post");
        check_pkt(1'b0, "ar_post", 8'h80, 8'h00, 8'h77);
        check("ar_post_cnt", cnt, 11'd1);
        check("ar_post_col", col, 1'b0);
        check("ar_post_ovf", ovf, 1'b0);

        check("ferr_end", ferr, 0);
        check("fd_full_frame_none", fd0_cnt, 0);
        check("fd4_total", fd4_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Transmit-side back end of the tile-classification pipeline. Sits after the SNN and CNN cores and the output mux.
- Captures each per-tile result (SNN or CNN), tags it with its route and its tile index, and buffers it in a small FIFO.
- Serialises each buffered result as a framed UART packet (8N1). This is the TX counterpart of the host UART receive path.

Parameters:
DVSR, 100, clocks per oversample tick (tick = clk_freq/(16*baud))
SB_TICK, 16, ticks in the stop bit
FIFO_DEPTH, 16, result FIFO entries (power of 2)
NUM_TILES, 1200, tiles per frame (640x480 / 16x16)
IDX_W, 11, tile-index width (must satisfy 2^IDX_W >= NUM_TILES)

Ports:
iClk  in  1  system clock
iRst  in  1  reset, asynchronous, active-low
iCNN_Valid  in  1  1-clock pulse, CNN result valid
iCNN_Result  in  8  CNN tile result
iSNN_Valid  in  1  1-clock pulse, SNN result valid
iSNN_Result  in  8  SNN tile result
oTx  out  1  UART serial line, idle high
oBusy  out  1  high while the FIFO is non-empty or a packet is in flight
oOverflow  out  1  sticky: a result was dropped because the FIFO was full
oCollision  out  1  sticky: both valids were asserted in the same cycle
oTileCount  out  IDX_W  index that will be assigned to the next accepted result
oFrameDone  out  1  1-clock pulse when the packet for tile NUM_TILES-1 finishes

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst is asynchronous and active-low. Asserting iRst immediately forces the following, including mid-packet:
  - oTx=1, oBusy=0, oOverflow=0, oCollision=0, oTileCount=0, oFrameDone=0.
  - FIFO empty, all FSMs in IDLE, tick and bit counters at 0.
- Capture (each rising edge):
  - iCNN_Valid=1: push {route=1, iCNN_Result, oTileCount}.
  - Else iSNN_Valid=1: push {route=0, iSNN_Result, oTileCount}.
  - Both valids high: push the CNN entry, drop the SNN result, set oCollision.
- Push accounting:
  - An accepted push increments oTileCount. It wraps from NUM_TILES-1 to 0.
  - FIFO full at the push edge: the entry is dropped, oOverflow is set, and oTileCount still increments so later indices stay frame-accurate.
  - Simultaneous push and pop on a full FIFO: the push is accepted.
- Baud tick:
  - Counter 0..DVSR-1 produces a 1-clock tick at DVSR-1.
  - The counter is held at 0 while the TX FSM is IDLE, so the start bit is exactly 16*DVSR clocks long.
- Packet format, each byte LSB first:
  - B0 = 0xA5.
  - B1 = {route, 4'b0000, idx[10:8]}.
  - B2 = idx[7:0].
  - B3 = result.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop, latch the entry, load B0, drive oTx=0, go to START. The entry is written at edge E0; oTx falls at edge E1.
  - START: 16 ticks, then go to DATA with the bit counter at 0.
  - DATA: shift out one bit per 16 ticks; after bit 7, go to STOP.
  - STOP: oTx=1 for SB_TICK ticks. If more bytes remain in the packet, load the next byte and go directly to START with no idle gap. Otherwise return to IDLE.
  - A queued next packet starts on the clock after IDLE is re-entered.
- oFrameDone pulses on the clock where the STOP state of the last byte ends and the latched idx equals NUM_TILES-1.
- oBusy = FIFO non-empty OR TX FSM not in IDLE.
- Widths: FIFO word = 1+8+IDX_W bits. Pointers are log2(FIFO_DEPTH)+1 bits, with the extra MSB used for the full/empty distinction.

Optional Feature:
- Macro: RESULT_TX_CHECKSUM_EN.
- Defined: a fifth byte, B4 = B1 XOR B2 XOR B3, is appended and sent after B3. Packet = 5 bytes.
- Undefined: packet = 4 bytes and the XOR logic is absent.
- FIFO, capture and flag behaviour are identical in both builds.

Test Plan:
- DVSR=2, SB_TICK=16, single CNN pulse with result 0x3C at tile 0 -> oTx falls one clock after the push. Line decodes as A5,80,00,3C, each bit 32 clocks. oBusy falls after the final stop bit.
- Two SNN pulses with 0x11 then 0x22 on back-to-back clocks -> packets A5,00,00,11 then A5,00,01,22. No idle high gap between bytes; one IDLE clock between packets. oTileCount=2.
- iCNN_Valid and iSNN_Valid high in the same cycle (CNN=0x55, SNN=0x66) -> only A5,80,00,55 is sent. oCollision=1 and stays 1.
- 20 pulses back-to-back with FIFO_DEPTH=16 and one entry popped after the first pulse -> exactly 17 packets sent, oOverflow=1, oTileCount=20, dropped indices absent from the stream.
- NUM_TILES=4, 5 results -> oFrameDone pulses once, after the idx-3 packet stop bit. The fifth packet carries idx 0.
- iRst asserted low mid-DATA of B2, released after 3 clocks -> oTx=1 asynchronously, all flags 0, oBusy=0. The next pulse produces a clean packet with idx 0.
